inv_rotate: RTL and testbench

Inverse of the rho (Rotate) stage of the slice-serial permutation datapath.
- Accepts a full state as NUM_SLICES consecutive 25-bit slices, then emits the state with every lane rotated back by its rho offset.
- Used on the reverse/decode path and as the bench's round-trip checker for Rotate.
- Exposes the same start/count/write/done stage handshake as the other datapath stages.

---
 rtl/inv_rotate_if.sv | 21 ++
 rtl/inv_rotate.sv | 102 ++++++++++
 tb/tb_inv_rotate.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/inv_rotate_if.sv
// Stage handshake bundle for inv_rotate: start/write/count control, slice in, slice out and done.
interface inv_rotate_if #(
   parameter int NUM_CELLS = 25
) ();
   logic                 start;
   logic                 write;
   logic                 count;
   logic [NUM_CELLS-1:0] data_in;
   logic                 done;
   logic [NUM_CELLS-1:0] data_out;

   modport master (
      output start, write, count, data_in,
      input  done, data_out
   );

   modport slave (
      input  start, write, count, data_in,
      output done, data_out
   );
endinterface

// File: rtl/inv_rotate.sv
// Inverse rho stage: buffers a full slice-serial state, then replays it with each lane
// rotated back by its rho offset (output slice k, lane i reads stored slice k + r[i]).
module inv_rotate #(
   parameter int NUM_CELLS     = 25,
   parameter int NUM_SLICES    = 64,
   parameter int LEN_SLICE_IDX = 6
) (
   input  logic         clk,
   input  logic         rst,
   inv_rotate_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

   // Rho offsets indexed by i = x + 5*y.
   localparam logic [5:0] ROT [25] = '{
      6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
      6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
      6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
      6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
      6'd18, 6'd2,  6'd61, 6'd56, 6'd14
   };

   localparam logic [LEN_SLICE_IDX-1:0] LAST_IDX = LEN_SLICE_IDX'(NUM_SLICES - 1);

   state_t                   state_q, state_d;
   logic [LEN_SLICE_IDX-1:0] wr_q, wr_d;
   logic [LEN_SLICE_IDX-1:0] rd_q, rd_d;
   logic [NUM_CELLS-1:0]     data_out_q, data_out_d;
   logic                     done_q, done_d;
   logic                     mem_we;
   logic [NUM_CELLS-1:0]     rot_slice;

   logic [NUM_CELLS-1:0] mem [NUM_SLICES];

   // Every lane reads its own slice address, so the read side is a per-bit mux.
   for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_bit
      logic [LEN_SLICE_IDX-1:0] src_idx;
      assign src_idx       = rd_q + ROT[gi];
      assign rot_slice[gi] = mem[src_idx][gi];
   end

   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      data_out_d = data_out_q;
      done_d     = done_q;
      mem_we     = 1'b0;
      if (bus.start) begin
         state_d = LOAD;
         wr_d    = '0;
         rd_d    = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (bus.write) begin
                  mem_we = 1'b1;
                  wr_d   = wr_q + 1'b1;
                  if (wr_q == LAST_IDX) state_d = EMIT;
               end
            end
            EMIT: begin
               if (bus.count) begin
                  data_out_d = rot_slice;
                  rd_d       = rd_q + 1'b1;
                  if (rd_q == LAST_IDX) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            DONE:    done_d = 1'b1;
            default: done_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wr_q       <= '0;
         rd_q       <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
      end
   end

   // Slice storage carries no reset; a new load always overwrites it.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_q] <= bus.data_in;
   end

   assign bus.data_out = data_out_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_inv_rotate.sv
// Self-checking bench for inv_rotate: directed impulses plus forward-rho round trips, scoreboarded.
module tb_inv_rotate;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   inv_rotate_if #(.NUM_CELLS(25)) bus ();

   inv_rotate #(.NUM_CELLS(25), .NUM_SLICES(64), .LEN_SLICE_IDX(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [24:0] sb_q [$];
   logic [24:0] src  [64];
   logic [24:0] fwd  [64];
   logic [24:0] expv [64];
   logic [24:0] last_out;

   int rot_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                        41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_arrays();
      for (int z = 0; z < 64; z++) begin
         fwd[z]  = '0;
         expv[z] = '0;
      end
   endtask

   // Forward rho: lane i of slice z comes from slice z - r[i]; inverse must return src.
   task automatic rand_roundtrip();
      for (int z = 0; z < 64; z++) src[z] = 25'($urandom());
      for (int z = 0; z < 64; z++)
         for (int i = 0; i < 25; i++)
            fwd[z][i] = src[(z - rot_tab[i]) & 63][i];
      for (int z = 0; z < 64; z++) expv[z] = src[z];
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_done", {31'd0, bus.done}, 32'd0);
   endtask

   task automatic load_state(input int gap_pct, input int n);
      for (int z = 0; z < n; z++) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            bus.write = 1'b0;
            bus.count = 1'b1;
            tick();
         end
         bus.count   = 1'b0;
         bus.write   = 1'b1;
         bus.data_in = fwd[z];
         tick();
      end
      bus.write = 1'b0;
   endtask

   task automatic emit_check(input int gap_pct, input int n);
      logic [24:0] e;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            bus.count = 1'b0;
            bus.write = 1'b1;
            tick();
            bus.write = 1'b0;
            chk("hold_data", {7'd0, bus.data_out}, {7'd0, last_out});
            chk("hold_done", {31'd0, bus.done}, 32'd0);
         end
         bus.count = 1'b1;
         sb_q.push_back(expv[k]);
         tick();
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("slice%0d", k), {7'd0, bus.data_out}, {7'd0, e});
            last_out = e;
         end
         chk($sformatf("done%0d", k), {31'd0, bus.done}, (k == 63) ? 32'd1 : 32'd0);
      end
      bus.count = 1'b0;
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.write   = 1'b0;
      bus.count   = 1'b0;
      bus.data_in = '0;
      last_out    = '0;
      repeat (2) tick();
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_data", {7'd0, bus.data_out}, 32'd0);
      rst = 1'b1;
      tick();

      // Lane (0,0) identity with alternating bit0
      clear_arrays();
      for (int z = 0; z < 64; z++) begin
         fwd[z]  = (z % 2 == 0) ? 25'd1 : 25'd0;
         expv[z] = fwd[z];
      end
      do_start();
      load_state(0, 64);
      emit_check(0, 64);

      // Impulse with offset 1
      clear_arrays();
      fwd[5]  = 25'h2;
      expv[4] = 25'h2;
      do_start();
      load_state(0, 64);
      emit_check(0, 64);

      // Wrap-around impulses
      clear_arrays();
      fwd[0]   = 25'h4;
      fwd[63]  = 25'h1 << 24;
      expv[2]  = 25'h4;
      expv[49] = 25'h1 << 24;
      do_start();
      load_state(0, 64);
      emit_check(0, 64);

      // Random round trips with stalls
      for (int t = 0; t < 20; t++) begin
         rand_roundtrip();
         do_start();
         load_state(30, 64);
         emit_check(30, 64);
      end

      // Abort mid-EMIT with count, then start with write in LOAD
      rand_roundtrip();
      do_start();
      load_state(0, 64);
      emit_check(0, 30);
      bus.start = 1'b1;
      bus.count = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.count = 1'b0;
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_data", {7'd0, bus.data_out}, {7'd0, last_out});
      bus.start   = 1'b1;
      bus.write   = 1'b1;
      bus.data_in = 25'h1ABCDEF;
      tick();
      bus.start = 1'b0;
      bus.write = 1'b0;
      rand_roundtrip();
      load_state(30, 64);
      emit_check(30, 64);

      // DONE held for 100 cycles despite write/count activity
      for (int c = 0; c < 100; c++) begin
         bus.write = 1'($urandom());
         bus.count = 1'($urandom());
         tick();
         chk("done_hold", {31'd0, bus.done}, 32'd1);
         chk("done_data", {7'd0, bus.data_out}, {7'd0, last_out});
      end
      bus.write = 1'b0;
      bus.count = 1'b0;

      // Asynchronous reset mid-LOAD at wr_idx 40
      rand_roundtrip();
      do_start();
      load_state(0, 40);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_done", {31'd0, bus.done}, 32'd0);
      chk("arst_data", {7'd0, bus.data_out}, 32'd0);
      last_out = '0;
      tick();
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         bus.write = 1'b1;
         bus.count = 1'b1;
         tick();
         chk("post_rst_done", {31'd0, bus.done}, 32'd0);
         chk("post_rst_data", {7'd0, bus.data_out}, 32'd0);
      end
      bus.write = 1'b0;
      bus.count = 1'b0;
      rand_roundtrip();
      do_start();
      load_state(30, 64);
      emit_check(30, 64);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
